// File: rtl/csr_counter_unit.sv
// Performance-counter CSR unit: machine counters, user shadows, inhibit/enable/event CSRs.
// Read data and illegal flag are combinational (zero latency); writes/increments land on the next edge.
// No backpressure: one access per cycle, always accepted or flagged illegal.
//
// params_i layout: [4] read_enable, [3] write_enable, [2] input_select (already applied by decode),
//                  [1:0] write_func (00 none, 01 RW, 10 RS, 11 RC).
// csr_addr_i layout: [11:10] access (11 = read-only), [9:8] lowest privilege, [7:0] index.
module csr_counter_unit #(
    parameter int NUM_HPM       = 4,
    parameter int COUNTER_WIDTH = 64,
    parameter int TIME_DIVIDE   = 1,
    localparam int HPM_N        = (NUM_HPM > 0) ? NUM_HPM : 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             instr_retired_i,
    input  logic [HPM_N-1:0] hpm_event_i,
    input  logic [1:0]       priv_mode_i,
    input  logic [11:0]      csr_addr_i,
    input  logic [4:0]       params_i,
    input  logic [31:0]      reg_in_i,
    output logic [31:0]      read_value_o,
    output logic             illegal_instr_exception_o
);

    localparam int CW = COUNTER_WIDTH;
    localparam int PW = (TIME_DIVIDE > 1) ? $clog2(TIME_DIVIDE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TIME_DIVIDE - 1);

    // Implemented bits of mcountinhibit / mcounteren; bit1 of inhibit (time) is hardwired 0.
    localparam logic [31:0] HPM_MASK = 32'(((64'd1 << NUM_HPM) - 64'd1) << 3);
    localparam logic [31:0] INH_MASK = HPM_MASK | 32'h0000_0005;
    localparam logic [31:0] EN_MASK  = HPM_MASK | 32'h0000_0007;

    localparam logic [1:0] PRIV_M  = 2'b11;
    localparam logic [1:0] ACC_RO  = 2'b11;
    localparam logic [1:0] FN_NONE = 2'b00;
    localparam logic [1:0] FN_RW   = 2'b01;
    localparam logic [1:0] FN_RS   = 2'b10;

    // Architectural state
    logic [CW-1:0] mcycle_q,   mcycle_d;
    logic [CW-1:0] minstret_q, minstret_d;
    logic [CW-1:0] time_q,     time_d;
    logic [PW-1:0] prescale_q, prescale_d;
    logic [CW-1:0] hpm_q       [HPM_N];
    logic [CW-1:0] hpm_d       [HPM_N];
    logic [31:0]   mhpmevent_q [HPM_N];
    logic [31:0]   mhpmevent_d [HPM_N];
    logic [31:0]   mcountinhibit_q, mcountinhibit_d;
    logic [31:0]   mcounteren_q,    mcounteren_d;

    // Decode
    logic        rd_en, wr_en;
    logic [1:0]  wr_func;
    logic [4:0]  idx;
    logic        hi_half, is_shadow, is_cnt_space, hpm_ok;
    logic        cnt_exists, is_en, is_inh, is_evt, addr_exists;
    logic        illegal, do_write, wr_cnt;
    logic [CW-1:0] cnt_sel;
    logic [63:0]   cnt_wide;
    logic [31:0]   evt_sel, csr_old, wdata;
    logic          tick;
    logic          unused_input_select;

    assign rd_en   = params_i[4];
    assign wr_en   = params_i[3];
    assign wr_func = params_i[1:0];
    // Operand selection already happened upstream; the flag is carried only for completeness.
    assign unused_input_select = params_i[2];

    // Merge a 32-bit write into one half of a counter, leaving the other half untouched.
    function automatic logic [CW-1:0] merge_half(input logic [CW-1:0] cur, input logic hi,
                                                 input logic [31:0] w);
        logic [CW-1:0] r;
        r = cur;
        if (hi) r[CW-1:32] = w[CW-33:0];
        else    r[31:0]    = w;
        return r;
    endfunction

    // Address decode: which CSR is addressed and whether it exists in this configuration.
    always_comb begin
        idx          = csr_addr_i[4:0];
        hi_half      = csr_addr_i[7];
        is_shadow    = (csr_addr_i[11:8] == 4'hC);
        is_cnt_space = ((csr_addr_i[11:8] == 4'hB) || is_shadow) && (csr_addr_i[6:5] == 2'b00);
        hpm_ok       = (int'(idx) >= 3) && (int'(idx) < 3 + NUM_HPM);
        // Time is reachable only through the read-only shadow.
        cnt_exists   = is_cnt_space &&
                       ((idx == 5'd0) || (idx == 5'd2) || ((idx == 5'd1) && is_shadow) || hpm_ok);
        is_en        = (csr_addr_i == 12'h306);
        is_inh       = (csr_addr_i == 12'h320);
        is_evt       = (csr_addr_i[11:5] == 7'h19) && hpm_ok;
        addr_exists  = cnt_exists || is_en || is_inh || is_evt;
    end

    // Old-value read mux, zero-extended above the implemented counter width.
    always_comb begin
        cnt_sel = '0;
        evt_sel = '0;
        case (idx)
            5'd0:    cnt_sel = mcycle_q;
            5'd1:    cnt_sel = time_q;
            5'd2:    cnt_sel = minstret_q;
            default: begin
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (int'(idx) == 3 + i) begin
                        cnt_sel = hpm_q[i];
                        evt_sel = mhpmevent_q[i];
                    end
                end
            end
        endcase
        cnt_wide = 64'(cnt_sel);
        csr_old  = '0;
        if (cnt_exists)  csr_old = hi_half ? cnt_wide[63:32] : cnt_wide[31:0];
        else if (is_en)  csr_old = mcounteren_q;
        else if (is_inh) csr_old = mcountinhibit_q;
        else if (is_evt) csr_old = evt_sel;
    end

    // Legality: existence, privilege level, read-only writes, and counter-enable gating of shadows.
    always_comb begin
        illegal = ((rd_en || wr_en) && !addr_exists) ||
                  (csr_addr_i[9:8] > priv_mode_i) ||
                  (wr_en && (csr_addr_i[11:10] == ACC_RO)) ||
                  ((priv_mode_i != PRIV_M) && is_cnt_space && is_shadow && !mcounteren_q[idx]);
        case (wr_func)
            FN_RW:   wdata = reg_in_i;
            FN_RS:   wdata = csr_old | reg_in_i;
            default: wdata = csr_old & ~reg_in_i;
        endcase
        do_write = wr_en && !illegal && (wr_func != FN_NONE);
        // Shadows are read-only, so any legal counter write targets the machine copy.
        wr_cnt   = do_write && cnt_exists;
    end

    assign illegal_instr_exception_o = illegal;
    assign read_value_o              = (rd_en && !illegal) ? csr_old : 32'h0;

    // Next state: increments first, then a same-cycle write overrides the written half.
    always_comb begin
        tick       = (prescale_q == PS_LAST);
        prescale_d = tick ? '0 : prescale_q + PW'(1);
        time_d     = tick ? time_q + CW'(1) : time_q;

        mcycle_d = mcountinhibit_q[0] ? mcycle_q : mcycle_q + CW'(1);
        if (wr_cnt && (idx == 5'd0)) mcycle_d = merge_half(mcycle_q, hi_half, wdata);

        minstret_d = (instr_retired_i && !mcountinhibit_q[2]) ? minstret_q + CW'(1) : minstret_q;
        if (wr_cnt && (idx == 5'd2)) minstret_d = merge_half(minstret_q, hi_half, wdata);

        for (int i = 0; i < HPM_N; i++) begin
            hpm_d[i]       = hpm_q[i];
            mhpmevent_d[i] = mhpmevent_q[i];
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (hpm_event_i[i] && (mhpmevent_q[i] != 32'h0) && !mcountinhibit_q[3 + i])
                hpm_d[i] = hpm_q[i] + CW'(1);
            if (wr_cnt && (int'(idx) == 3 + i))
                hpm_d[i] = merge_half(hpm_q[i], hi_half, wdata);
            if (do_write && is_evt && (int'(idx) == 3 + i))
                mhpmevent_d[i] = wdata;
        end

        mcountinhibit_d = mcountinhibit_q;
        if (do_write && is_inh) mcountinhibit_d = wdata & INH_MASK;
        mcounteren_d = mcounteren_q;
        if (do_write && is_en) mcounteren_d = wdata & EN_MASK;
    end

    // State registers; reset has priority over any write or increment.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            mcycle_q        <= '0;
            minstret_q      <= '0;
            time_q          <= '0;
            prescale_q      <= '0;
            mcountinhibit_q <= '0;
            mcounteren_q    <= '0;
            for (int i = 0; i < HPM_N; i++) begin
                hpm_q[i]       <= '0;
                mhpmevent_q[i] <= '0;
            end
        end else begin
            mcycle_q        <= mcycle_d;
            minstret_q      <= minstret_d;
            time_q          <= time_d;
            prescale_q      <= prescale_d;
            mcountinhibit_q <= mcountinhibit_d;
            mcounteren_q    <= mcounteren_d;
            for (int i = 0; i < HPM_N; i++) begin
                hpm_q[i]       <= hpm_d[i];
                mhpmevent_q[i] <= mhpmevent_d[i];
            end
        end
    end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Directed bench for csr_counter_unit (NUM_HPM=4, COUNTER_WIDTH=40, TIME_DIVIDE=4).
// Inputs change on the falling edge; outputs are checked 1 time unit later, well before the rising edge.
// Expected values are hand-computed from the cycle-by-cycle sequence noted beside each step.
module tb_csr_counter_unit;

    localparam logic [1:0] PM = 2'b11;
    localparam logic [1:0] PS = 2'b01;
    localparam logic [1:0] PU = 2'b00;
    localparam logic [1:0] F_NONE = 2'b00;
    localparam logic [1:0] F_RW   = 2'b01;
    localparam logic [1:0] F_RS   = 2'b10;
    localparam logic [1:0] F_RC   = 2'b11;

    logic        clock;
    logic        reset;
    logic        instr_retired;
    logic [3:0]  hpm_event;
    logic [1:0]  priv_mode;
    logic [11:0] csr_addr;
    logic [4:0]  params;
    logic [31:0] reg_in;
    logic [31:0] read_value;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    csr_counter_unit #(
        .NUM_HPM       (4),
        .COUNTER_WIDTH (40),
        .TIME_DIVIDE   (4)
    ) dut (
        .clock_i                   (clock),
        .reset_i                   (reset),
        .instr_retired_i           (instr_retired),
        .hpm_event_i               (hpm_event),
        .priv_mode_i               (priv_mode),
        .csr_addr_i                (csr_addr),
        .params_i                  (params),
        .reg_in_i                  (reg_in),
        .read_value_o              (read_value),
        .illegal_instr_exception_o (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One access window: drive on the falling edge, settle, then the caller checks.
    task automatic win(input logic [1:0] pv, input logic [11:0] a, input logic re, input logic we,
                       input logic [1:0] fn, input logic [31:0] v);
        @(negedge clock);
        priv_mode = pv;
        csr_addr  = a;
        params    = {re, we, 1'b0, fn};
        reg_in    = v;
        #1;
    endtask

    task automatic rd(input logic [1:0] pv, input logic [11:0] a);
        win(pv, a, 1'b1, 1'b0, F_NONE, 32'h0);
    endtask

    task automatic wr(input logic [1:0] pv, input logic [11:0] a, input logic [1:0] fn,
                      input logic [31:0] v);
        win(pv, a, 1'b1, 1'b1, fn, v);
    endtask

    initial begin
        reset = 1'b1; instr_retired = 1'b0; hpm_event = 4'h0;
        priv_mode = PM; csr_addr = 12'h0; params = 5'h0; reg_in = 32'h0;

        // Reset held for edges 5, 15, 25
        rd(PM, 12'hB00); chk("reset_mcycle", read_value, 32'h0);
        rd(PM, 12'h306); chk("reset_mcounteren", read_value, 32'h0);
        rd(PM, 12'hB00); reset = 1'b0; chk("mcycle_0", read_value, 32'h0);
        rd(PM, 12'hB00); chk("mcycle_1", read_value, 32'h1);
        rd(PM, 12'hB00); chk("mcycle_2", read_value, 32'h2);
        rd(PM, 12'hB80); chk("mcycle_hi_0", read_value, 32'h0);

        // Low-half write and carry into the high half
        wr(PM, 12'hB00, F_RW, 32'hFFFF_FFFF); chk("mcycle_old", read_value, 32'h4);
        chk("mcycle_wr_legal", 32'(illegal), 32'h0);
        rd(PM, 12'hB00); chk("mcycle_written", read_value, 32'hFFFF_FFFF);
        rd(PM, 12'hB00); chk("mcycle_carry_lo", read_value, 32'h0);
        rd(PM, 12'hB80); chk("mcycle_carry_hi", read_value, 32'h1);

        // High-half write truncated to 40 bits; low half keeps its pre-increment value (2)
        wr(PM, 12'hB80, F_RW, 32'hFFFF_FFFF); chk("mcycle_hi_old", read_value, 32'h1);
        rd(PM, 12'hB00); chk("mcycle_lo_after_hi_wr", read_value, 32'h2);
        rd(PM, 12'hB80); chk("mcycle_hi_truncated", read_value, 32'h0000_00FF);

        // Inhibit cycle and instret; the edge of the write still counts mcycle (4 -> 5)
        wr(PM, 12'h320, F_RS, 32'h5); chk("inhibit_old", read_value, 32'h0);
        rd(PM, 12'h320); instr_retired = 1'b1; chk("inhibit_set", read_value, 32'h5);
        for (int i = 0; i < 9; i++) begin
            rd(PM, 12'hB02); chk("minstret_frozen", read_value, 32'h0);
        end
        rd(PM, 12'hB00); chk("mcycle_frozen", read_value, 32'h5);
        wr(PM, 12'h320, F_RC, 32'h4); chk("inhibit_rc_old", read_value, 32'h5);
        rd(PM, 12'hB02); chk("minstret_inhibit_lag", read_value, 32'h0);
        rd(PM, 12'hB02); chk("minstret_resumed", read_value, 32'h1);
        rd(PM, 12'hB00); instr_retired = 1'b0; chk("mcycle_still_frozen", read_value, 32'h5);

        // Privilege gating
        rd(PU, 12'hC00); chk("u_cycle_illegal", 32'(illegal), 32'h1);
        chk("u_cycle_rdata0", read_value, 32'h0);
        wr(PM, 12'h306, F_RS, 32'h1); chk("mcounteren_old", read_value, 32'h0);
        rd(PU, 12'hC00); chk("u_cycle_legal", 32'(illegal), 32'h0);
        chk("u_cycle_value", read_value, 32'h5);
        wr(PU, 12'hC00, F_RW, 32'h1234); chk("u_cycle_write_illegal", 32'(illegal), 32'h1);
        chk("u_cycle_write_rdata0", read_value, 32'h0);
        rd(PM, 12'hB07); chk("hpm_unimpl_illegal", 32'(illegal), 32'h1);
        chk("hpm_unimpl_rdata0", read_value, 32'h0);
        rd(PS, 12'hC02); chk("s_instret_gated", 32'(illegal), 32'h1);
        rd(PU, 12'hB00); chk("u_mcycle_priv", 32'(illegal), 32'h1);

        // HPM counter 3 with event enabled, then disabled
        wr(PM, 12'h323, F_RW, 32'h1); chk("mhpmevent3_old", read_value, 32'h0);
        rd(PM, 12'hB03); hpm_event = 4'b0001; chk("hpm3_start", read_value, 32'h0);
        for (int i = 0; i < 4; i++) rd(PM, 12'hB03);
        rd(PM, 12'hB03); hpm_event = 4'b0000; chk("hpm3_count5", read_value, 32'h5);
        wr(PM, 12'h323, F_RW, 32'h0); chk("mhpmevent3_rd", read_value, 32'h1);
        for (int i = 0; i < 5; i++) begin
            rd(PM, 12'hB03); hpm_event = 4'b0011;
        end
        rd(PM, 12'hB03); hpm_event = 4'b0000; chk("hpm3_disabled", read_value, 32'h5);
        rd(PM, 12'hB04); chk("hpm4_no_event_cfg", read_value, 32'h0);

        // Write minstret in the same cycle as a retirement: the increment is dropped
        wr(PM, 12'hB02, F_RW, 32'h100); instr_retired = 1'b1; chk("minstret_old", read_value, 32'h2);
        rd(PM, 12'hB02); instr_retired = 1'b0; chk("minstret_written", read_value, 32'h100);
        rd(PM, 12'hB02); chk("minstret_hold", read_value, 32'h100);

        // Mid-run reset clears everything; then time advances once per 4 cycles
        rd(PM, 12'hB00); reset = 1'b1;
        rd(PM, 12'hB00); reset = 1'b0; chk("rst_mcycle", read_value, 32'h0);
        rd(PM, 12'hB02); chk("rst_minstret", read_value, 32'h0);
        rd(PM, 12'hB03); chk("rst_hpm3", read_value, 32'h0);
        rd(PM, 12'h320); chk("rst_inhibit", read_value, 32'h0);
        rd(PM, 12'h306); chk("rst_mcounteren", read_value, 32'h0);
        for (int i = 0; i < 10; i++) win(PM, 12'h0, 1'b0, 1'b0, F_NONE, 32'h0);
        rd(PM, 12'hC01); chk("time_15cyc", read_value, 32'h3);
        rd(PM, 12'hC01); chk("time_16cyc", read_value, 32'h4);
        rd(PM, 12'hC81); chk("time_hi", read_value, 32'h0);
        wr(PM, 12'hC01, F_RW, 32'h0); chk("time_ro_write", 32'(illegal), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_counter_unit.md
# csr_counter_unit

Parametrised performance-counter CSR unit for the RV32 core: implements the machine counters (mcycle, minstret, mhpmcounter3..), their user read-only shadows (cycle, time, instret, hpmcounter3..), and the counter control CSRs (mcountinhibit, mcounteren, mhpmevent3..). Sits beside the main CSR block in execute; decode supplies the CSR address and csr_params_t, and this unit returns read data and an illegal-instruction flag. It adds configurable counter count and width, inhibit, privilege gating and a time prescaler.

## Interface

- NUM_HPM, 4, number of implemented hpm counters (0..29), mapped to indices 3..3+NUM_HPM-1
- COUNTER_WIDTH, 64, implemented counter width (33..64); bits above read as zero
- TIME_DIVIDE, 1, clock cycles per time increment (>=1)

- clock  input  1  core clock
- reset  input  1  synchronous, active-high; one clock; all state cleared on the rising edge while high
- instr_retired  input  1  one instruction retired this cycle
- hpm_event  input  NUM_HPM  event pulses; bit i feeds mhpmcounter(3+i)
- priv_mode  input  priv_mode_t  current privilege (U=00, S=01, M=11)
- csr_addr  input  12  CSR address (csr_addr_t layout)
- params  input  csr_params_t  read_enable, write_enable, input_select, write_func
- reg_in  input  32  write operand (rs1 or zero-extended imm, already selected by decode)
- read_value  output  32  old CSR value; 0 when read_enable low or access illegal
- illegal_instr_exception  output  1  access is illegal

## Operation

- Address map: mcycle 0xB00, minstret 0xB02, mhpmcounter 0xB03+i, high halves 0xB80/0xB82/0xB83+i; shadows cycle 0xC00, time 0xC01, instret 0xC02, hpmcounter 0xC03+i, high halves 0xC80..; mcounteren 0x306, mcountinhibit 0x320, mhpmevent 0x323+i. All other addresses, including hpm indices >= 3+NUM_HPM, are nonexistent.
- No machine-writable time register; time exists only as shadow 0xC01/0xC81.
- Illegal when any of: read_enable or write_enable high and address nonexistent; csr_addr.priv > priv_mode; write_enable high and csr_addr.access == RO; priv_mode != M, address is a 0xCxx shadow, and mcounteren bit (addr[4:0]) is 0 (S-mode also needs nothing further; no scounteren).
- Write value: RW -> reg_in; RS -> old | reg_in; RC -> old & ~reg_in; NONE -> no write. Written on the next clock edge only if write_enable high and not illegal.
- Low-half write replaces bits [31:0]; high-half write replaces bits [COUNTER_WIDTH-1:32]; bits above COUNTER_WIDTH discarded.
- mcountinhibit: bit0 cycle, bit2 instret, bit 3+i hpm; bit1 and unimplemented bits hardwired 0. mcounteren: bits 0,1,2,3+i writable, rest 0. mhpmevent: full 32-bit storage, no decoding.
- Increments per cycle (not in reset): mcycle +1 unless inhibited; minstret +1 if instr_retired and not inhibited; hpm i +1 if hpm_event[i], mhpmevent[i] != 0, not inhibited; time +1 when prescaler reaches TIME_DIVIDE-1 (prescaler then wraps to 0); time ignores mcountinhibit.
- Counters wrap modulo 2^COUNTER_WIDTH silently.
- Same-cycle CSR write and increment to the same counter: written half takes the written value; the other half keeps its pre-increment value (no carry). Write to an inhibit bit affects increments starting the following cycle.

## Timing

- read_value and illegal_instr_exception are combinational from current inputs and state; zero-latency read of pre-edge value.
- State updates on rising clock edge; a write is visible to a read on the next cycle.
- Reset: all counters, time, prescaler, mcountinhibit, mcounteren, mhpmevent = 0. Outputs during reset follow the combinational rule (read of any counter returns 0 after first reset edge).
- Reset asserted concurrently with a write or increment: reset wins.
- Illegal access: no state change; read_value 0; increments continue normally.

## Test plan

- Reset 3 cycles, release, M-mode read 0xB00 each cycle -> 0,1,2,...; read 0xB80 -> 0.
- Write mcycle=0xFFFF_FFFF via RW, next cycle read 0xB00 -> 0x0, 0xB80 -> 0x1 (carry into high half); COUNTER_WIDTH=40: write 0xB80 = 0xFFFF_FFFF -> reads 0x0000_00FF.
- Set mcountinhibit=0x5 via RS; pulse instr_retired 10 cycles -> minstret and mcycle frozen; RC 0x4 -> minstret resumes counting, mcycle still frozen.
- U-mode read 0xC00 with mcounteren=0 -> illegal=1, read_value 0; set mcounteren bit0 -> legal, returns cycle; U-mode CSRRW 0xC00 -> illegal; M-mode read 0xB03+NUM_HPM -> illegal.
- mhpmevent3=1, hpm_event[0] high 5 cycles -> mhpmcounter3=5; mhpmevent3=0 -> no count. TIME_DIVIDE=4, 16 cycles -> time=4.
- Write 0xB02 while instr_retired high -> minstret equals written value (increment dropped); assert reset mid-run -> all counters 0 next cycle.
